// File: rtl/lcv_div_iter_del_if.sv
// Handshake bundle for the iterative divider: operand channel in, result channel out.
// The master side issues operands and accepts results; the slave side is the divider.
interface lcv_div_iter_del_if #(
  parameter int WIDTH = 32
);
  logic             inp_valid;
  logic             inp_ready;
  logic [WIDTH-1:0] inp_a;
  logic [WIDTH-1:0] inp_b;
  logic             inp_signed;
  logic             outp_valid;
  logic             outp_ready;
  logic [WIDTH-1:0] outp_quot;
  logic [WIDTH-1:0] outp_rem;
  logic             outp_div_zero;

  modport master (
    output inp_valid, inp_a, inp_b, inp_signed, outp_ready,
    input  inp_ready, outp_valid, outp_quot, outp_rem, outp_div_zero
  );

  modport slave (
    input  inp_valid, inp_a, inp_b, inp_signed, outp_ready,
    output inp_ready, outp_valid, outp_quot, outp_rem, outp_div_zero
  );
endinterface

// File: rtl/lcv_div_iter_del.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Signed operands are reduced to magnitudes up front and the signs are
// reapplied in a single fix-up cycle, so the core loop is purely unsigned.
// Quotient truncates toward zero; remainder follows the dividend's sign.
module lcv_div_iter_del #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  lcv_div_iter_del_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dvd_reg;      // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_reg;      // divisor magnitude
  logic [WIDTH-1:0] quot_reg;     // quotient magnitude, built LSB-in
  logic [WIDTH-1:0] rem_reg;      // partial remainder; always < divisor so WIDTH bits hold it
  logic [WIDTH-1:0] a_orig_reg;   // raw dividend, returned as remainder on divide-by-zero
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             zero_reg;

  logic             inp_ready_reg;
  logic             outp_valid_reg;
  logic [WIDTH-1:0] outp_quot_reg;
  logic [WIDTH-1:0] outp_rem_reg;
  logic             outp_div_zero_reg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_t;        // one extra bit so the trial compare never overflows
  logic             rem_ge;

  // Operand magnitudes and the trial-subtract compare for the current step
  always_comb begin
    a_mag = bus.inp_a;
    b_mag = bus.inp_b;
    if (bus.inp_signed && bus.inp_a[WIDTH-1]) a_mag = -bus.inp_a;
    if (bus.inp_signed && bus.inp_b[WIDTH-1]) b_mag = -bus.inp_b;
    rem_t  = {rem_reg, dvd_reg[WIDTH-1]};
    rem_ge = (rem_t >= {1'b0, dvs_reg});
  end

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      dvd_reg           <= '0;
      dvs_reg           <= '0;
      quot_reg          <= '0;
      rem_reg           <= '0;
      a_orig_reg        <= '0;
      neg_q_reg         <= 1'b0;
      neg_r_reg         <= 1'b0;
      zero_reg          <= 1'b0;
      inp_ready_reg     <= 1'b0;
      outp_valid_reg    <= 1'b0;
      outp_quot_reg     <= '0;
      outp_rem_reg      <= '0;
      outp_div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          inp_ready_reg <= 1'b1;
          if (bus.inp_valid && inp_ready_reg) begin
            dvd_reg       <= a_mag;
            dvs_reg       <= b_mag;
            a_orig_reg    <= bus.inp_a;
            neg_q_reg     <= bus.inp_signed & (bus.inp_a[WIDTH-1] ^ bus.inp_b[WIDTH-1]);
            neg_r_reg     <= bus.inp_signed & bus.inp_a[WIDTH-1];
            zero_reg      <= (bus.inp_b == '0);
            rem_reg       <= '0;
            quot_reg      <= '0;
            cnt_reg       <= CNT_W'(WIDTH - 1);
            inp_ready_reg <= 1'b0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          dvd_reg  <= {dvd_reg[WIDTH-2:0], 1'b0};
          quot_reg <= {quot_reg[WIDTH-2:0], rem_ge};
          // Difference is below the divisor, so dropping the top bit is exact
          rem_reg  <= rem_ge ? (rem_t[WIDTH-1:0] - dvs_reg) : rem_t[WIDTH-1:0];
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        FIX: begin
          if (zero_reg) begin
            outp_quot_reg <= '1;
            outp_rem_reg  <= a_orig_reg;
          end else begin
            outp_quot_reg <= neg_q_reg ? -quot_reg : quot_reg;
            outp_rem_reg  <= neg_r_reg ? -rem_reg : rem_reg;
          end
          outp_div_zero_reg <= zero_reg;
          outp_valid_reg    <= 1'b1;
          state_reg         <= DONE;
        end
        DONE: begin
          if (bus.outp_ready) begin
            outp_valid_reg <= 1'b0;
            inp_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.inp_ready     = inp_ready_reg;
  assign bus.outp_valid    = outp_valid_reg;
  assign bus.outp_quot     = outp_quot_reg;
  assign bus.outp_rem      = outp_rem_reg;
  assign bus.outp_div_zero = outp_div_zero_reg;
endmodule
